// File: rtl/skinny_sbox_pkg.sv
// Shared constants and types for the masked SKINNY-128 S-box blocks.
// Mask-slice offsets select each gadget's 2-bit refresh mask.
package skinny_sbox_pkg;

  localparam int ISBOX_LAT = 8;

  localparam int MI_B2 = 0;
  localparam int MI_B3 = 2;
  localparam int MI_B7 = 4;
  localparam int MI_B5 = 6;
  localparam int MI_B1 = 8;
  localparam int MI_B0 = 10;
  localparam int MI_B6 = 12;
  localparam int MI_B4 = 14;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/skinny_isbox8_cfn.sv
// Single 2-share NOR-XOR gadget: f = z ^ NOR(x, y), two register stages.
// Shares are packed {share1, share0}; m is the 2-bit refresh mask.
module skinny_isbox8_cfn (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic [1:0] z,
  input  logic [1:0] m,
  output logic [1:0] f
);

  logic g1;
  logic g0;
  logic t1;
  logic t0;

  // g carries the masked cross-free terms; t folds in the cross terms
  always_ff @(posedge clk) begin
    if (rst) begin
      g1 <= 1'b0;
      g0 <= 1'b0;
      t1 <= 1'b0;
      t0 <= 1'b0;
    end else begin
      g1 <= (~x[1] & ~y[1]) ^ m[1];
      g0 <= (x[0] & y[0]) ^ m[0];
      t1 <= (~x[1] & y[0]) ^ m[0] ^ g1 ^ z[0];
      t0 <= (~y[1] & x[0]) ^ m[1] ^ g0 ^ z[1];
    end
  end

  assign f = {t1, t0};

endmodule

// File: rtl/skinny_isbox8_para1_hs.sv
// Masked inverse SKINNY-128 8-bit S-box with valid/ready wrapper.
// Define SKINNY_ISBOX8_SCRUB_EN to clear latched operands on release.
module skinny_isbox8_para1_hs
  import skinny_sbox_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  si1,
  input  logic [7:0]  si0,
  input  logic [15:0] r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  bo1,
  output logic [7:0]  bo0
);

  localparam logic [2:0] CNT_LAST = 3'(ISBOX_LAT - 1);

  state_t      state;
  state_t      state_n;
  logic [2:0]  cnt;
  logic [7:0]  s1_q;
  logic [7:0]  s0_q;
  logic [15:0] r_q;
  logic        accept;
  logic        drain;

  logic [1:0]  o [8];
  logic [1:0]  b [8];

  assign accept = (state == IDLE) && in_valid;
  assign drain  = (state == DONE) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      s1_q  <= '0;
      s0_q  <= '0;
      r_q   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        s1_q <= si1;
        s0_q <= si0;
        r_q  <= r;
        cnt  <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 3'd1;
      end
`ifdef SKINNY_ISBOX8_SCRUB_EN
      if (drain) begin
        s1_q <= '0;
        s0_q <= '0;
        r_q  <= '0;
      end
`endif
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = BUSY;
      end
      BUSY: begin
        if (cnt == CNT_LAST) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (drain) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar i = 0; i < 8; i++) begin : g_bits
    assign o[i]   = {s1_q[i], s0_q[i]};
    assign bo1[i] = b[i][1];
    assign bo0[i] = b[i][0];
  end

  // level 1
  skinny_isbox8_cfn u_b2 (
    .clk (clk), .rst (rst),
    .x   (o[3]), .y (o[1]), .z (o[0]),
    .m   (r_q[MI_B2 +: 2]),
    .f   (b[2])
  );

  skinny_isbox8_cfn u_b3 (
    .clk (clk), .rst (rst),
    .x   (o[7]), .y (o[6]), .z (o[4]),
    .m   (r_q[MI_B3 +: 2]),
    .f   (b[3])
  );

  skinny_isbox8_cfn u_b7 (
    .clk (clk), .rst (rst),
    .x   (o[2]), .y (o[7]), .z (o[1]),
    .m   (r_q[MI_B7 +: 2]),
    .f   (b[7])
  );

  skinny_isbox8_cfn u_b5 (
    .clk (clk), .rst (rst),
    .x   (o[6]), .y (o[5]), .z (o[7]),
    .m   (r_q[MI_B5 +: 2]),
    .f   (b[5])
  );

  // level 2
  skinny_isbox8_cfn u_b1 (
    .clk (clk), .rst (rst),
    .x   (o[5]), .y (b[3]), .z (o[3]),
    .m   (r_q[MI_B1 +: 2]),
    .f   (b[1])
  );

  skinny_isbox8_cfn u_b0 (
    .clk (clk), .rst (rst),
    .x   (b[3]), .y (b[2]), .z (o[5]),
    .m   (r_q[MI_B0 +: 2]),
    .f   (b[0])
  );

  // levels 3 and 4
  skinny_isbox8_cfn u_b6 (
    .clk (clk), .rst (rst),
    .x   (b[2]), .y (b[1]), .z (o[2]),
    .m   (r_q[MI_B6 +: 2]),
    .f   (b[6])
  );

  skinny_isbox8_cfn u_b4 (
    .clk (clk), .rst (rst),
    .x   (b[7]), .y (b[6]), .z (o[6]),
    .m   (r_q[MI_B4 +: 2]),
    .f   (b[4])
  );

endmodule

// File: tb/tb_skinny_isbox8_para1_hs.sv
// Directed bench for the masked inverse SKINNY-128 8-bit S-box.
// Inputs change 1 time unit after posedge; outputs sampled there too.
module tb_skinny_isbox8_para1_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  si1;
  logic [7:0]  si0;
  logic [15:0] r;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  bo1;
  logic [7:0]  bo0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  skinny_isbox8_para1_hs dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .si1       (si1),
    .si0       (si0),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bo1       (bo1),
    .bo0       (bo0)
  );

  function automatic logic nor2(input logic p, input logic q);
    return ~p & ~q;
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] o);
    logic [7:0] y;
    y[2] = o[0] ^ nor2(o[3], o[1]);
    y[3] = o[4] ^ nor2(o[7], o[6]);
    y[7] = o[1] ^ nor2(o[2], o[7]);
    y[5] = o[7] ^ nor2(o[6], o[5]);
    y[1] = o[3] ^ nor2(o[5], y[3]);
    y[0] = o[5] ^ nor2(y[3], y[2]);
    y[6] = o[2] ^ nor2(y[2], y[1]);
    y[4] = o[6] ^ nor2(y[7], y[6]);
    return y;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic chk_ne(input string tag, input logic [15:0] obs,
                        input logic [15:0] other);
    n_chk++;
    assert (obs !== other) n_pass++;
    else $error("FAIL %s: got %h want anything but %h", tag, obs, other);
  endtask

  task automatic run_op(input logic [7:0] a1, input logic [7:0] a0,
                        input logic [15:0] m,
                        output logic [7:0] y1, output logic [7:0] y0,
                        output int lat);
    si1 = a1;
    si0 = a0;
    r = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    y1 = bo1;
    y0 = bo0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  y1, y0, ref1, h1, h0, x, a1;
    logic [15:0] m;
    logic [255:0] seen;
    int lat, gap, nv, nseen;
    logic [7:0] ya1, ya0;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    si1 = '0;
    si0 = '0;
    r = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_bo1", 16'(bo1), 16'h00);
    chk("rst_bo0", 16'(bo0), 16'h00);
    rst = 1'b0;
    #10;

    // 0x65 -> 0x00, latency of 8 edges
    run_op(8'h00, 8'h65, 16'h0000, y1, y0, lat);
    chk("lat_first", 16'(lat), 16'd8);
    chk("y_65", 16'(y1 ^ y0), 16'h00);
    chk("ready_in_done", 16'(in_ready), 16'd0);
    take();
    chk("idle_after_take", 16'(in_ready), 16'd1);

    // 0xFF -> 0xFF with and without mask
    run_op(8'hA5, 8'h5A, 16'h0000, y1, y0, lat);
    chk("y_ff_r0", 16'(y1 ^ y0), 16'hFF);
    ref1 = y1;
    take();
    run_op(8'hA5, 8'h5A, 16'h3C5A, y1, y0, lat);
    chk("y_ff_rm", 16'(y1 ^ y0), 16'hFF);
    chk_ne("mask_used", 16'(y1), 16'(ref1));
    take();

    // 0x00 -> 0xAC
    run_op(8'h3C, 8'h3C, 16'hFFFF, y1, y0, lat);
    chk("y_00", 16'(y1 ^ y0), 16'hAC);
    chk("lat_00", 16'(lat), 16'd8);
    take();

    // hold in DONE with ignored in_valid pulses
    run_op(8'h12, 8'h34, 16'h5555, h1, h0, lat);
    chk("y_hold", 16'(h1 ^ h0), 16'(isb(8'h26)));
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      si1 = 8'(i * 37);
      si0 = 8'(i * 91);
      r = 16'(i * 4099);
      @(posedge clk);
      #1;
      chk("hold_valid", 16'(out_valid), 16'd1);
      chk("hold_ready", 16'(in_ready), 16'd0);
      chk("hold_bo1", 16'(bo1), 16'(h1));
      chk("hold_bo0", 16'(bo0), 16'(h0));
    end
    in_valid = 1'b0;
    take();
    chk("hold_release", 16'(out_valid), 16'd0);

    // reset at BUSY cnt=4 aborts
    si1 = 8'h11;
    si0 = 8'h22;
    r = 16'h1234;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid", 16'(out_valid), 16'd0);
    chk("abort_ready", 16'(in_ready), 16'd1);
    chk("abort_bo1", 16'(bo1), 16'h00);
    chk("abort_bo0", 16'(bo0), 16'h00);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) nv++;
    end
    chk("abort_no_late", 16'(nv), 16'd0);

    // back-to-back with out_ready held high
    out_ready = 1'b1;
    si1 = 8'hC3;
    si0 = 8'h0F;
    r = 16'hA5A5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    si1 = 8'h5E;
    si0 = 8'h71;
    r = 16'h0F0F;
    gap = 0;
    ya1 = '0;
    ya0 = '0;
    nv = 0;
    while (!in_ready && gap < 40) begin
      @(posedge clk);
      #1;
      gap++;
      if (out_valid && nv == 0) begin
        ya1 = bo1;
        ya0 = bo0;
        nv = 1;
      end
    end
    chk("b2b_gap", 16'(gap), 16'd9);
    chk("b2b_y_a", 16'(ya1 ^ ya0), 16'(isb(8'hCC)));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_lat_b", 16'(lat), 16'd8);
    chk("b2b_y_b", 16'(bo1 ^ bo0), 16'(isb(8'h2F)));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_idle", 16'(in_ready), 16'd1);

    // all 256 inputs, random split and mask
    seen = '0;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      a1 = 8'($urandom);
      m = 16'($urandom);
      run_op(a1, a1 ^ x, m, y1, y0, lat);
      chk("exh_y", 16'(y1 ^ y0), 16'(isb(x)));
      if (lat != 8) chk("exh_lat", 16'(lat), 16'd8);
      seen[y1 ^ y0] = 1'b1;
      take();
    end
    nseen = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) nseen++;
    chk("exh_bijective", 16'(nseen), 16'd256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
